// File: rtl/dzcpu_useq.sv
// Micro-sequencer for the DZCPU: walks the micro-op ROM from opcode LUT entry points,
// handles the 0xCB page jump, and emits PC/flag/instruction-done strobes.
// Optional watchdog: define DZCPU_USEQ_WATCHDOG_EN to abort instructions after 48 micro-ops.
module dzcpu_useq (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [7:0]  iMop,
  input  logic        iMopValid,
  input  logic [7:0]  iFlowIdx,
  input  logic [7:0]  iCbFlowIdx,
  input  logic [12:0] iUop,
  input  logic        iFlagZ,
  input  logic        iStall,
  output logic [7:0]  oUopAddr,
  output logic [3:0]  oOp,
  output logic [4:0]  oOperand,
  output logic        oOpValid,
  output logic        oPcInc,
  output logic        oFlagUpdate,
  output logic        oInstrDone,
  output logic        oFetch,
  output logic        oWdTimeout
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXEC    = 2'd1,
    S_CB_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] OP_JCB = 4'hF;

  state_t      r_state;
  logic [7:0]  r_upc;

  logic [3:0]  w_flow;
  logic [3:0]  w_op;
  logic [4:0]  w_operand;
  logic        w_run;
  logic        w_jcb;
  logic        w_code_pc_inc;
  logic        w_code_flag_upd;
  logic        w_code_end;
  logic        w_wd_hit;
  logic        w_unused;

  assign w_flow    = iUop[12:9];
  assign w_op      = iUop[8:5];
  assign w_operand = iUop[4:0];
  assign w_run     = (r_state == S_EXEC) && !iStall;
  assign w_jcb     = (w_op == OP_JCB);
  // The opcode byte itself is only consumed through the external LUTs.
  assign w_unused  = ^iMop;

  // Flow-field decode; codes 9-15 fall through as plain op.
  always_comb begin
    w_code_pc_inc   = 1'b0;
    w_code_flag_upd = 1'b0;
    w_code_end      = 1'b0;
    case (w_flow)
      4'd1: w_code_pc_inc = 1'b1;
      4'd2: w_code_end = 1'b1;
      4'd3: begin
        w_code_pc_inc = 1'b1;
        w_code_end    = 1'b1;
      end
      4'd4: begin
        w_code_flag_upd = 1'b1;
        w_code_end      = 1'b1;
      end
      4'd5: begin
        w_code_pc_inc   = 1'b1;
        w_code_flag_upd = 1'b1;
        w_code_end      = 1'b1;
      end
      4'd6: begin
        w_code_pc_inc = 1'b1;
        w_code_end    = iFlagZ;
      end
      4'd7: begin
        w_code_pc_inc = 1'b1;
        w_code_end    = !iFlagZ;
      end
      4'd8: w_code_flag_upd = 1'b1;
      default: w_code_end = 1'b0;
    endcase
  end

`ifdef DZCPU_USEQ_WATCHDOG_EN
  localparam logic [5:0] WD_LIMIT = 6'd48;
  logic [5:0] r_wd_cnt;

  // Hit on the micro-op that brings the count to the limit.
  assign w_wd_hit = w_run && (r_wd_cnt == (WD_LIMIT - 6'd1));

  // Micro-op count since the last entry into EXEC.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_wd_cnt <= 6'd0;
    end else if (iStall) begin
      r_wd_cnt <= r_wd_cnt;
    end else if ((r_state != S_EXEC) && iMopValid) begin
      r_wd_cnt <= 6'd0;
    end else if (w_run) begin
      r_wd_cnt <= r_wd_cnt + 6'd1;
    end else begin
      r_wd_cnt <= r_wd_cnt;
    end
  end
`else
  assign w_wd_hit = 1'b0;
`endif

  // Sequencer state and micro-PC.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state <= S_FETCH;
      r_upc   <= 8'd0;
    end else if (!iStall) begin
      case (r_state)
        S_FETCH: begin
          if (iMopValid) begin
            r_upc   <= iFlowIdx;
            r_state <= S_EXEC;
          end
        end
        S_CB_WAIT: begin
          if (iMopValid) begin
            r_upc   <= iCbFlowIdx;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_wd_hit) begin
            r_state <= S_FETCH;
          end else if (w_jcb) begin
            r_state <= S_CB_WAIT;
          end else if (w_code_end) begin
            r_state <= S_FETCH;
          end else begin
            r_upc <= r_upc + 8'd1;
          end
        end
        default: begin
          r_state <= S_FETCH;
          r_upc   <= 8'd0;
        end
      endcase
    end
  end

  assign oUopAddr    = r_upc;
  assign oFetch      = (r_state == S_FETCH);
  assign oOpValid    = w_run;
  assign oOp         = w_run ? w_op : 4'd0;
  assign oOperand    = w_run ? w_operand : 5'd0;
  assign oPcInc      = w_run && w_code_pc_inc;
  assign oFlagUpdate = w_run && w_code_flag_upd;
  // A jcb hands over to the CB page, so the instruction is not finished yet.
  assign oInstrDone  = w_run && w_code_end && !w_jcb && !w_wd_hit;
  assign oWdTimeout  = w_wd_hit;

endmodule

// File: doc/dzcpu_useq.md
DZCPU_USEQ -- requirements
Module: dzcpu_useq

Interface
REQ-001 The block SHALL have one clock and one reset: iClock is the single clock, and iReset is an asynchronous, active-high reset.
REQ-002 iClock  in  1  rising-edge clock for all state.
REQ-003 iReset  in  1  asynchronous active-high reset.
REQ-004 iMop  in  8  opcode byte from the memory data bus.
REQ-005 iMopValid  in  1  iMop valid this cycle (memory read complete).
REQ-006 iFlowIdx  in  8  main opcode LUT output for iMop (combinational, external).
REQ-007 iCbFlowIdx  in  8  0xCB-page LUT output for iMop (combinational, external).
REQ-008 iUop  in  13  micro-op word returned combinationally by the micro-op ROM for oUopAddr.
REQ-009 iFlagZ  in  1  current Z flag.
REQ-010 iStall  in  1  datapath stall; freezes the sequencer.
REQ-011 oUopAddr  out  8  micro-op ROM address (micro-PC).
REQ-012 oOp  out  4  decoded operation field, iUop[8:5].
REQ-013 oOperand  out  5  decoded operand field, iUop[4:0].
REQ-014 oOpValid  out  1  oOp/oOperand are to be executed this cycle.
REQ-015 oPcInc  out  1  one-cycle strobe that increments the architectural PC.
REQ-016 oFlagUpdate  out  1  one-cycle strobe to commit ALU flags.
REQ-017 oInstrDone  out  1  one-cycle strobe on the final micro-op of an instruction.
REQ-018 oFetch  out  1  high while waiting for an opcode byte.
REQ-019 oWdTimeout  out  1  watchdog abort strobe (see Configuration).

Function
REQ-020 The flow field iUop[12:9] SHALL decode as: 0=op, 1=inc, 2=eof, 3=inc_eof, 4=eof_fu, 5=inc_eof_fu, 6=inc_eof_z, 7=inc_eof_nz, 8=update_flags; codes 9-15 SHALL behave as op.
REQ-021 Operation code 4'hF SHALL be jcb (the 0xCB page jump).
REQ-022 The block SHALL implement states FETCH, EXEC and CB_WAIT.
- FETCH: oFetch=1, oOpValid=0.
- On iMopValid=1 the block SHALL set uPC<=iFlowIdx and move to EXEC.
REQ-023 In EXEC with iStall=0, oOpValid SHALL be 1, and oOp and oOperand SHALL be driven from iUop.
REQ-024 In EXEC, oPcInc SHALL equal 1 for flow codes 1, 3, 5, 6 and 7.
REQ-025 In EXEC, oFlagUpdate SHALL equal 1 for flow codes 4, 5 and 8.
REQ-026 In EXEC, the end condition SHALL be:
- codes 2, 3, 4, 5: always end;
- code 6: end when iFlagZ=1;
- code 7: end when iFlagZ=0.
On end, oInstrDone=1 and the next state is FETCH; otherwise uPC<=uPC+1.
REQ-027 uPC increment SHALL wrap from 255 to 0 modulo 256, with no other side effect.
REQ-028 In EXEC, a jcb operation SHALL strobe oOpValid and SHALL then move to CB_WAIT.
REQ-029 In CB_WAIT, oOpValid=0; on iMopValid=1 the block SHALL set uPC<=iCbFlowIdx and move to EXEC.
REQ-030 When iStall=1, state, uPC and the watchdog count SHALL hold, and oOpValid, oPcInc, oFlagUpdate and oInstrDone SHALL be 0.
REQ-031 Latency SHALL be: one micro-op per unstalled EXEC cycle, and the first micro-op in the cycle after opcode acceptance.
REQ-032 If iMopValid=1 outside FETCH or CB_WAIT, the block SHALL ignore it.

Reset
REQ-033 On iReset=1 the block SHALL asynchronously enter FETCH with uPC=0 and the watchdog count=0.
REQ-034 During reset, all outputs SHALL be 0 except oFetch=1 and oUopAddr=0.
REQ-035 Reset asserted mid-instruction (EXEC or CB_WAIT) SHALL abandon the instruction without emitting any strobe.

Configuration
REQ-036 With the macro DZCPU_USEQ_WATCHDOG_EN defined, a 6-bit counter SHALL behave as follows:
- it clears on entry to EXEC and increments per executed micro-op;
- on reaching 48 it forces FETCH, pulses oWdTimeout for one cycle, and suppresses oInstrDone.
REQ-037 With DZCPU_USEQ_WATCHDOG_EN undefined, no counter SHALL exist, oWdTimeout SHALL be constant 0, and instruction length SHALL be unbounded.

Verification
REQ-038 Scenario: iFlowIdx=1, ROM[1..4] flow={1,1,0,3} -> exactly four oOpValid cycles at addresses 1,2,3,4; oPcInc on addresses 1, 2 and 4; oInstrDone at address 4; then oFetch=1.
REQ-039 Scenario: ROM[19] flow=6, iFlagZ=1 -> oPcInc and oInstrDone at 19; ROM[20] is not addressed. Repeat with iFlagZ=0 -> the sequence continues to address 20.
REQ-040 Scenario: ROM[15] op=4'hF -> the block enters CB_WAIT; iMop=8'h7C with iCbFlowIdx=16 -> oUopAddr=16 in the next cycle; flow code 4 gives oFlagUpdate and oInstrDone.
REQ-041 Scenario: iStall=1 for 3 cycles at address 52 -> oUopAddr stays 52 and no strobes are emitted; after release the sequence resumes at 52.
REQ-042 Scenario: iReset pulsed while oUopAddr=55 -> oUopAddr=0 and oFetch=1 immediately, with no oInstrDone.
REQ-043 Scenario: watchdog enabled, ROM all flow=0 -> oWdTimeout after 48 micro-ops and a return to FETCH; watchdog disabled -> uPC wraps from 255 to 0 and oWdTimeout stays 0.
